// File: rtl/ooo_hazard_sequencer.sv
// Pipeline hazard/redirect sequencer: stalls, branch and privileged redirects, fence.i, halt.
// Optional stall-cycle counter port enabled by defining HAZARD_PERF_CNT_EN.
module ooo_hazard_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_mem_busy,
  input  logic        d_mem_busy,
  input  logic        hazard,
  input  logic        rob_full,
  input  logic        rob_empty,
  input  logic        mispredict,
  input  logic        trap,
  input  logic        ret,
  input  logic [31:0] epc,
  input  logic [31:0] trap_vec,
  input  logic        ifence,
  input  logic        dflushed,
  input  logic        iflushed,
  input  logic        halt,
  output logic        pc_en,
  output logic        npc_sel,
  output logic        insert_priv_pc,
  output logic [31:0] priv_pc,
  output logic        fetch_decode_flush,
  output logic        decode_execute_flush,
  output logic        execute_commit_flush,
  output logic        stall_fetch_decode,
  output logic        stall_ex,
  output logic        ifence_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        iren
);

  typedef enum logic [2:0] {
    RUN,
    MISPRED,
    TRAP_DRAIN,
    TRAP_REDIR,
    IFENCE_WAIT,
    HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] priv_pc_q, priv_pc_d;
  logic        ifence_pulse_q, ifence_pulse_d;

  logic run_busy;
  logic fence_done;

  assign run_busy   = hazard | rob_full | i_mem_busy | d_mem_busy;
  assign fence_done = dflushed & iflushed & rob_empty;
  assign priv_pc    = priv_pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= RUN;
      priv_pc_q      <= '0;
      ifence_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      priv_pc_q      <= priv_pc_d;
      ifence_pulse_q <= ifence_pulse_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    priv_pc_d      = priv_pc_q;
    ifence_pulse_d = 1'b0;
    // Privileged events win over everything and also swallow a coincident mispredict.
    if ((state_q != HALTED) && (trap || ret)) begin
      state_d   = TRAP_DRAIN;
      priv_pc_d = trap ? trap_vec : epc;
    end else begin
      case (state_q)
        RUN: begin
          if (mispredict)              state_d = MISPRED;
          else if (ifence)             state_d = IFENCE_WAIT;
          else if (halt && rob_empty)  state_d = HALTED;
        end
        MISPRED:    state_d = RUN;
        TRAP_DRAIN: if (!d_mem_busy) state_d = TRAP_REDIR;
        TRAP_REDIR: state_d = RUN;
        IFENCE_WAIT: begin
          if (fence_done) begin
            state_d        = RUN;
            ifence_pulse_d = 1'b1;
          end
        end
        HALTED:     state_d = HALTED;
        default:    state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_en                = 1'b0;
    npc_sel              = 1'b0;
    insert_priv_pc       = 1'b0;
    fetch_decode_flush   = 1'b0;
    decode_execute_flush = 1'b0;
    execute_commit_flush = 1'b0;
    stall_fetch_decode   = 1'b0;
    stall_ex             = d_mem_busy;
    ifence_flush         = 1'b0;
    iren                 = 1'b1;
    case (state_q)
      RUN: begin
        stall_fetch_decode = run_busy;
        pc_en              = ~run_busy;
        // The fence redirect lands in the first RUN cycle after the caches report clean.
        ifence_flush       = ifence_pulse_q;
        fetch_decode_flush = ifence_pulse_q;
      end
      MISPRED: begin
        pc_en                = 1'b1;
        npc_sel              = 1'b1;
        fetch_decode_flush   = 1'b1;
        decode_execute_flush = 1'b1;
      end
      TRAP_DRAIN: begin
        iren               = 1'b0;
        stall_fetch_decode = 1'b1;
      end
      TRAP_REDIR: begin
        iren                 = 1'b0;
        pc_en                = 1'b1;
        insert_priv_pc       = 1'b1;
        fetch_decode_flush   = 1'b1;
        decode_execute_flush = 1'b1;
        execute_commit_flush = 1'b1;
      end
      IFENCE_WAIT: stall_fetch_decode = 1'b1;
      HALTED: begin
        iren               = 1'b0;
        stall_fetch_decode = 1'b1;
        stall_ex           = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles_q <= '0;
    end else if (!pc_en && (state_q != HALTED) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_ooo_hazard_sequencer.sv
// Self-checking bench for ooo_hazard_sequencer: directed scenarios plus a randomized run
// against a flag-based behavioural model of the sequencing rules.
module tb_ooo_hazard_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        i_mem_busy, d_mem_busy, hazard, rob_full, rob_empty;
  logic        mispredict, trap, ret, ifence, dflushed, iflushed, halt;
  logic [31:0] epc, trap_vec;
  logic        pc_en, npc_sel, insert_priv_pc, fetch_decode_flush, decode_execute_flush;
  logic        execute_commit_flush, stall_fetch_decode, stall_ex, ifence_flush, iren;
  logic [31:0] priv_pc;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  ooo_hazard_sequencer dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .i_mem_busy           (i_mem_busy),
    .d_mem_busy           (d_mem_busy),
    .hazard               (hazard),
    .rob_full             (rob_full),
    .rob_empty            (rob_empty),
    .mispredict           (mispredict),
    .trap                 (trap),
    .ret                  (ret),
    .epc                  (epc),
    .trap_vec             (trap_vec),
    .ifence               (ifence),
    .dflushed             (dflushed),
    .iflushed             (iflushed),
    .halt                 (halt),
    .pc_en                (pc_en),
    .npc_sel              (npc_sel),
    .insert_priv_pc       (insert_priv_pc),
    .priv_pc              (priv_pc),
    .fetch_decode_flush   (fetch_decode_flush),
    .decode_execute_flush (decode_execute_flush),
    .execute_commit_flush (execute_commit_flush),
    .stall_fetch_decode   (stall_fetch_decode),
    .stall_ex             (stall_ex),
    .ifence_flush         (ifence_flush),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles         (stall_cycles),
`endif
    .iren                 (iren)
  );

  always #5 CLK = ~CLK;

  // Output bundle: {pc_en, iren, npc_sel, insert_priv_pc, ifence_flush, fd_flush, de_flush, ec_flush, stall_fd, stall_ex}
  logic [9:0] outs;
  assign outs = {pc_en, iren, npc_sel, insert_priv_pc, ifence_flush, fetch_decode_flush,
                 decode_execute_flush, execute_commit_flush, stall_fetch_decode, stall_ex};

  localparam logic [9:0] V_IDLE    = 10'b1100000000;
  localparam logic [9:0] V_HAZ     = 10'b0100000010;
  localparam logic [9:0] V_DBUSY   = 10'b0100000011;
  localparam logic [9:0] V_MISP    = 10'b1110011000;
  localparam logic [9:0] V_DRAIN   = 10'b0000000010;
  localparam logic [9:0] V_DRAIN_B = 10'b0000000011;
  localparam logic [9:0] V_REDIR   = 10'b1001011100;
  localparam logic [9:0] V_FWAIT   = 10'b0100000010;
  localparam logic [9:0] V_FPULSE  = 10'b1100110000;
  localparam logic [9:0] V_HALT    = 10'b0000000010;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    {i_mem_busy, d_mem_busy, hazard, rob_full, mispredict, trap, ret} = '0;
    {ifence, dflushed, iflushed, halt} = '0;
    rob_empty = 1'b1;
    epc       = '0;
    trap_vec  = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL reset_outs: got %b want %b", outs, V_IDLE); else n_pass++;
    n_checks++;
    if (priv_pc !== 32'h0) $display("FAIL reset_priv_pc: got %h want 0", priv_pc); else n_pass++;
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL idle_after_reset: got %b want %b", outs, V_IDLE); else n_pass++;
    // Enter the drain sequence, then abort it with an asynchronous reset between edges.
    next_cycle();
    trap = 1'b1;
    trap_vec = 32'hDEAD_0000;
    next_cycle();
    trap = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_DRAIN) $display("FAIL abort_setup_drain: got %b want %b", outs, V_DRAIN); else n_pass++;
    #1 RST = 1'b1;
    #1;
    n_checks++;
    if ({outs, priv_pc} !== {V_IDLE, 32'h0})
      $display("FAIL async_abort: got %b/%h want %b/0", outs, priv_pc, V_IDLE);
    else n_pass++;
    next_cycle();
    RST = 1'b0;
  endtask

  task automatic test_hazard_stall();
    logic [9:0] exp;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      hazard = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (outs !== V_HAZ) $display("FAIL hazard_stall[%0d]: got %b want %b", i, outs, V_HAZ); else n_pass++;
    end
    next_cycle();
    hazard = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL hazard_release: got %b want %b", outs, V_IDLE); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      {rob_full, i_mem_busy, d_mem_busy} = 3'b100 >> k;
      exp = (k == 2) ? V_DBUSY : V_HAZ;
      @(negedge CLK);
      n_checks++;
      if (outs !== exp) $display("FAIL stall_source[%0d]: got %b want %b", k, outs, exp); else n_pass++;
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_mispredict();
    clear_inputs();
    next_cycle();
    mispredict = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL mispred_cycle0: got %b want %b", outs, V_IDLE); else n_pass++;
    next_cycle();
    mispredict = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_MISP) $display("FAIL mispred_redirect: got %b want %b", outs, V_MISP); else n_pass++;
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL mispred_return: got %b want %b", outs, V_IDLE); else n_pass++;
  endtask

  task automatic test_trap_drain();
    int stalls;
    logic [9:0] exp;
    clear_inputs();
    stalls = 0;
    next_cycle();
    trap = 1'b1;
    trap_vec = 32'h8000_0100;
    epc = 32'h0000_4444;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL trap_cycle0: got %b want %b", outs, V_IDLE); else n_pass++;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      trap = 1'b0;
      d_mem_busy = (c < 3);
      exp = (c < 3) ? V_DRAIN_B : V_DRAIN;
      @(negedge CLK);
      if (!pc_en) stalls++;
      n_checks++;
      if (outs !== exp) $display("FAIL trap_drain[%0d]: got %b want %b", c, outs, exp); else n_pass++;
    end
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if ({outs, priv_pc} !== {V_REDIR, 32'h8000_0100})
      $display("FAIL trap_redirect: got %b/%h want %b/80000100", outs, priv_pc, V_REDIR);
    else n_pass++;
    n_checks++;
    if (stalls !== 3) $display("FAIL trap_stall_count: got %0d want 3", stalls); else n_pass++;
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL trap_return: got %b want %b", outs, V_IDLE); else n_pass++;
    // mret selects epc rather than trap_vec.
    next_cycle();
    ret = 1'b1;
    epc = 32'h0000_2468;
    next_cycle();
    ret = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_DRAIN) $display("FAIL ret_drain: got %b want %b", outs, V_DRAIN); else n_pass++;
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if ({outs, priv_pc} !== {V_REDIR, 32'h0000_2468})
      $display("FAIL ret_redirect: got %b/%h want %b/00002468", outs, priv_pc, V_REDIR);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_ifence();
    int pulses;
    logic [9:0] exp;
    clear_inputs();
    pulses = 0;
    next_cycle();
    ifence = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL ifence_issue: got %b want %b", outs, V_IDLE); else n_pass++;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      ifence   = 1'b0;
      dflushed = (c >= 2);
      iflushed = (c >= 6);
      @(negedge CLK);
      if (ifence_flush) pulses++;
      exp = (c <= 6) ? V_FWAIT : ((c == 7) ? V_FPULSE : V_IDLE);
      n_checks++;
      if (outs !== exp) $display("FAIL ifence_seq[%0d]: got %b want %b", c, outs, exp); else n_pass++;
    end
    n_checks++;
    if (pulses !== 1) $display("FAIL ifence_pulse_count: got %0d want 1", pulses); else n_pass++;
    // A trap while waiting abandons the fence even if the caches report clean that cycle.
    next_cycle();
    dflushed = 1'b0;
    iflushed = 1'b0;
    ifence   = 1'b1;
    next_cycle();
    ifence   = 1'b0;
    next_cycle();
    trap     = 1'b1;
    trap_vec = 32'h8000_0200;
    dflushed = 1'b1;
    iflushed = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_FWAIT) $display("FAIL fence_trap_wait: got %b want %b", outs, V_FWAIT); else n_pass++;
    next_cycle();
    trap = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_DRAIN) $display("FAIL fence_trap_drain: got %b want %b", outs, V_DRAIN); else n_pass++;
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if ({outs, priv_pc} !== {V_REDIR, 32'h8000_0200})
      $display("FAIL fence_trap_redir: got %b/%h want %b/80000200", outs, priv_pc, V_REDIR);
    else n_pass++;
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL fence_abandoned: got %b want %b", outs, V_IDLE); else n_pass++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_trap_mispredict();
    bit saw_npc;
    int redir_at;
    clear_inputs();
    saw_npc  = 1'b0;
    redir_at = -1;
    next_cycle();
    trap       = 1'b1;
    mispredict = 1'b1;
    trap_vec   = 32'h8000_0300;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      trap       = 1'b0;
      mispredict = 1'b0;
      @(negedge CLK);
      if (npc_sel) saw_npc = 1'b1;
      if (insert_priv_pc && redir_at < 0) redir_at = c;
    end
    n_checks++;
    if (saw_npc !== 1'b0) $display("FAIL trap_beats_mispredict: npc_sel seen %0d want 0", saw_npc); else n_pass++;
    n_checks++;
    if (redir_at !== 2) $display("FAIL trap_seq_timing: redirect at %0d want 2", redir_at); else n_pass++;
    n_checks++;
    if (priv_pc !== 32'h8000_0300) $display("FAIL trap_seq_pc: got %h want 80000300", priv_pc); else n_pass++;
  endtask

  task automatic test_halt();
    clear_inputs();
    next_cycle();
    halt      = 1'b1;
    rob_empty = 1'b0;
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL halt_waits_rob: got %b want %b", outs, V_IDLE); else n_pass++;
    next_cycle();
    rob_empty = 1'b1;
    next_cycle();
    halt = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_HALT) $display("FAIL halted: got %b want %b", outs, V_HALT); else n_pass++;
    next_cycle();
    {trap, mispredict, ifence, d_mem_busy} = 4'b1111;
    next_cycle();
    clear_inputs();
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if (outs !== V_HALT) $display("FAIL halt_absorbing: got %b want %b", outs, V_HALT); else n_pass++;
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (outs !== V_IDLE) $display("FAIL halt_reset_exit: got %b want %b", outs, V_IDLE); else n_pass++;
  endtask

  // Reference model: which kind of cycle the sequencer is in, tracked as independent flags.
  bit          m_halted, m_drain, m_redir, m_misp, m_fwait, m_fpulse;
  logic [31:0] m_priv;
  logic [31:0] m_stalls;

  task automatic model_reset();
    {m_halted, m_drain, m_redir, m_misp, m_fwait, m_fpulse} = '0;
    m_priv   = '0;
    m_stalls = '0;
  endtask

  function automatic logic [9:0] model_expect();
    logic busy;
    busy = hazard | rob_full | i_mem_busy | d_mem_busy;
    if (m_halted) return 10'b0000000010;
    if (m_drain)  return {9'b000000001, d_mem_busy};
    if (m_redir)  return {9'b100101110, d_mem_busy};
    if (m_misp)   return {9'b111001100, d_mem_busy};
    if (m_fwait)  return {9'b010000001, d_mem_busy};
    return {~busy, 1'b1, 1'b0, 1'b0, m_fpulse, m_fpulse, 1'b0, 1'b0, busy, d_mem_busy};
  endfunction

  task automatic model_advance(input logic [9:0] exp);
    bit nf;
    nf = 1'b0;
    if (!exp[9] && !m_halted && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
    if (m_halted) begin
    end else if (trap || ret) begin
      {m_drain, m_redir, m_misp, m_fwait} = 4'b1000;
      m_priv = trap ? trap_vec : epc;
    end else if (m_drain) begin
      if (!d_mem_busy) begin m_drain = 1'b0; m_redir = 1'b1; end
    end else if (m_redir) begin
      m_redir = 1'b0;
    end else if (m_misp) begin
      m_misp = 1'b0;
    end else if (m_fwait) begin
      if (dflushed && iflushed && rob_empty) begin m_fwait = 1'b0; nf = 1'b1; end
    end else if (mispredict) begin
      m_misp = 1'b1;
    end else if (ifence) begin
      m_fwait = 1'b1;
    end else if (halt && rob_empty) begin
      m_halted = 1'b1;
    end
    m_fpulse = nf;
  endtask

  task automatic test_random();
    logic [9:0] exp;
    int halt_cnt;
    clear_inputs();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    model_reset();
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (m_halted && ++halt_cnt >= 4) begin
        RST = 1'b1;
        #1 RST = 1'b0;
        model_reset();
        halt_cnt = 0;
      end
      hazard     = ($urandom_range(99, 0) < 25);
      rob_full   = ($urandom_range(99, 0) < 10);
      i_mem_busy = ($urandom_range(99, 0) < 20);
      d_mem_busy = ($urandom_range(99, 0) < 30);
      rob_empty  = ($urandom_range(99, 0) < 50);
      mispredict = ($urandom_range(99, 0) < 8);
      trap       = ($urandom_range(99, 0) < 3);
      ret        = ($urandom_range(99, 0) < 2);
      ifence     = ($urandom_range(99, 0) < 4);
      halt       = ($urandom_range(99, 0) < 2);
      dflushed   = ($urandom_range(99, 0) < 50);
      iflushed   = ($urandom_range(99, 0) < 50);
      epc        = $urandom;
      trap_vec   = $urandom;
      @(negedge CLK);
      exp = model_expect();
      n_checks++;
      if ({outs, priv_pc} !== {exp, m_priv})
        $display("FAIL random[%0d]: got %b/%h want %b/%h", i, outs, priv_pc, exp, m_priv);
      else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (stall_cycles !== m_stalls)
        $display("FAIL random_stall_cycles[%0d]: got %0d want %0d", i, stall_cycles, m_stalls);
      else n_pass++;
`endif
      model_advance(exp);
    end
    clear_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_hazard_stall();
    test_mispredict();
    test_trap_drain();
    test_ifence();
    test_trap_mispredict();
    test_halt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
